// File: rtl/uart_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_receiver: 8N1 serial receiver with mid-bit sampling, level/ack handoff,
// framing-error pulse and sticky overrun flag.            Revision: 1.0
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int BIT_CYCLES  = comm_clk_frequency / baud_rate;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitn;
  logic [7:0]       shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      cnt         <= '0;
      bitn        <= '0;
      shift       <= '0;
      rx_data     <= 8'h00;
      rx_avail    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rx_meta     <= RxD;
      rxs         <= rx_meta;
      frame_error <= 1'b0;
      if (rx_ack && rx_avail)
        rx_avail <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt  <= '0;
            bitn <= '0;
            if (rxs) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rxs, shift[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7)
              state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
              // An ack arriving with the new byte frees the slot: the new byte wins.
              if (!rx_avail || rx_ack) begin
                rx_data  <= shift;
                rx_avail <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
